// File: rtl/bios_pkg.sv
// Shared FSM encoding and limits for the BIOS socket selector.
package bios_pkg;

    localparam int BIOS_NUM_MAX = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HOLD = 3'd1,
        ST_BOOT = 3'd2,
        ST_RUN  = 3'd3,
        ST_FAIL = 3'd4
    } bios_state_e;

    // Socket index width; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; clears to 0 on reset.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/bios_select_ctrl.sv
// BIOS SPI socket selector with chip-select routing; boot watchdog, retry and
// failover to the next socket are built only when BIOS_FAILOVER_EN is defined.
module bios_select_ctrl
    import bios_pkg::*;
#(
    parameter  int NUM_BIOS = 2,
    parameter  int BOOT_TMO = 1000000,
    localparam int SW       = sel_width(NUM_BIOS)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                Pwr_ok,
    input  logic                PciReset,
    input  logic [SW-1:0]       Next_Bios,
    input  logic                Post_Done,
    input  logic                SPI_PCH_CS0_N,
    output logic [SW-1:0]       Next_Bios_latch,
    output logic [SW-1:0]       Active_Bios,
    output logic [NUM_BIOS-1:0] BIOS_CS_N,
    output logic                Reset_Req,
    output logic                Boot_Fail,
    output bios_state_e         Dbg_State
);

    if (NUM_BIOS < 2 || NUM_BIOS > BIOS_NUM_MAX || BOOT_TMO < 4) begin : g_param_check
        $error("bios_select_ctrl: NUM_BIOS must be 2..8 and BOOT_TMO at least 4");
    end

    localparam logic [SW:0]   NB_LIM   = (SW+1)'(NUM_BIOS);
    localparam logic [SW-1:0] LAST_IDX = SW'(NUM_BIOS - 1);

    logic pwr_s;
    logic prst_s;
    logic post_s;

    sync_2ff u_sync_pwr  (.clk_i(CLK), .rst_i(RESET), .d_i(Pwr_ok),    .q_o(pwr_s));
    sync_2ff u_sync_prst (.clk_i(CLK), .rst_i(RESET), .d_i(PciReset),  .q_o(prst_s));
    sync_2ff u_sync_post (.clk_i(CLK), .rst_i(RESET), .d_i(Post_Done), .q_o(post_s));

    logic prst_q;
    logic prst_fall;
    logic prst_rise;

    assign prst_fall = prst_q & ~prst_s;
    assign prst_rise = ~prst_q & prst_s;

    // Out-of-range socket requests fall back to socket 0.
    logic [SW-1:0] latch_q;
    logic [SW-1:0] latch_d;

    always_comb begin
        latch_d = latch_q;
        if (!pwr_s && !prst_s) begin
            latch_d = '0;
        end else if (prst_s) begin
            latch_d = ({1'b0, Next_Bios} >= NB_LIM) ? '0 : Next_Bios;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prst_q  <= 1'b0;
            latch_q <= '0;
        end else begin
            prst_q  <= prst_s;
            latch_q <= latch_d;
        end
    end

    bios_state_e   state_q;
    logic [SW-1:0] active_q;
    logic          reload_ok;

`ifdef BIOS_FAILOVER_EN
    localparam int            WD_W    = $clog2(BOOT_TMO);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(BOOT_TMO - 1);

    logic [WD_W-1:0] wdog_q;
    logic [SW-1:0]   retry_q;
    logic            failover_q;
    logic            reset_req_q;
    logic            boot_fail_q;

    // After a failover the platform reset that follows must keep the new socket.
    assign reload_ok = ~failover_q;
`else
    assign reload_ok = 1'b1;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            active_q <= '0;
`ifdef BIOS_FAILOVER_EN
            wdog_q      <= '0;
            retry_q     <= '0;
            failover_q  <= 1'b0;
            reset_req_q <= 1'b0;
            boot_fail_q <= 1'b0;
`endif
        end else begin
`ifdef BIOS_FAILOVER_EN
            reset_req_q <= 1'b0;
`endif
            if (!pwr_s) begin
                state_q  <= ST_IDLE;
                active_q <= '0;
`ifdef BIOS_FAILOVER_EN
                wdog_q      <= '0;
                retry_q     <= '0;
                failover_q  <= 1'b0;
                boot_fail_q <= 1'b0;
`endif
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (prst_rise) begin
                            state_q <= ST_BOOT;
`ifdef BIOS_FAILOVER_EN
                            wdog_q     <= '0;
                            failover_q <= 1'b0;
`endif
                        end else if (prst_fall && reload_ok) begin
                            active_q <= latch_q;
`ifdef BIOS_FAILOVER_EN
                            retry_q  <= '0;
`endif
                        end
                    end
                    ST_BOOT: begin
                        if (prst_fall) begin
                            state_q  <= ST_HOLD;
                            active_q <= latch_q;
`ifdef BIOS_FAILOVER_EN
                            retry_q  <= '0;
`endif
                        end else if (post_s) begin
                            // POST completion beats a coincident watchdog expiry.
                            state_q <= ST_RUN;
`ifdef BIOS_FAILOVER_EN
                        end else if (wdog_q == WD_LAST) begin
                            if (retry_q < LAST_IDX) begin
                                active_q    <= (active_q == LAST_IDX) ? '0 : active_q + SW'(1);
                                retry_q     <= retry_q + SW'(1);
                                reset_req_q <= 1'b1;
                                failover_q  <= 1'b1;
                                state_q     <= ST_HOLD;
                            end else begin
                                boot_fail_q <= 1'b1;
                                state_q     <= ST_FAIL;
                            end
                        end else begin
                            wdog_q <= wdog_q + WD_W'(1);
`endif
                        end
                    end
                    ST_RUN: begin
                        if (prst_fall) begin
                            state_q  <= ST_HOLD;
                            active_q <= latch_q;
`ifdef BIOS_FAILOVER_EN
                            retry_q  <= '0;
`endif
                        end
                    end
                    ST_FAIL: begin
                        state_q <= ST_FAIL;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef BIOS_FAILOVER_EN
    assign Reset_Req = reset_req_q;
    assign Boot_Fail = boot_fail_q;
`else
    assign Reset_Req = 1'b0;
    assign Boot_Fail = 1'b0;
`endif

    // Only the active socket sees the PCH chip select, and none does once boot has failed.
    always_comb begin
        BIOS_CS_N = '1;
        for (int i = 0; i < NUM_BIOS; i++) begin
            if (state_q != ST_FAIL && active_q == SW'(i)) begin
                BIOS_CS_N[i] = SPI_PCH_CS0_N;
            end
        end
    end

    assign Next_Bios_latch = latch_q;
    assign Active_Bios     = active_q;
    assign Dbg_State       = state_q;

endmodule

// File: doc/bios_select_ctrl.md
BIOS_SELECT_CTRL -- requirements
Module: bios_select_ctrl

Interface
REQ-001 Parameter NUM_BIOS, 2, number of BIOS SPI sockets; legal range 2..8.
REQ-002 Parameter BOOT_TMO, 1000000, boot watchdog limit in CLK cycles; legal range >=4.
REQ-003 Derived width SW = clog2(NUM_BIOS), minimum 1.
REQ-004 CLK  in  1  free-running system clock; all state is sampled on its rising edge.
REQ-005 RESET  in  1  asynchronous, active-high block reset.
REQ-006 Pwr_ok  in  1  main power good, asynchronous to CLK.
REQ-007 PciReset  in  1  platform reset, active-low, asynchronous to CLK.
REQ-008 Next_Bios  in  SW  BIOS socket requested for the next reset.
REQ-009 Post_Done  in  1  BIOS POST complete (level), asynchronous to CLK.
REQ-010 SPI_PCH_CS0_N  in  1  BIOS chip select from the PCH, routed combinationally.
REQ-011 Next_Bios_latch  out  SW  registered next-socket value.
REQ-012 Active_Bios  out  SW  socket currently selected.
REQ-013 BIOS_CS_N  out  NUM_BIOS  per-socket chip selects, active-low.
REQ-014 Reset_Req  out  1  one-cycle pulse requesting a platform reset after failover.
REQ-015 Boot_Fail  out  1  all sockets failed to boot.

Function
REQ-016 Pwr_ok, PciReset and Post_Done SHALL pass through 2-flop synchronisers; all rules below use the synchronised values.
REQ-017 Next_Bios_latch SHALL track Next_Bios while PciReset is high, hold while PciReset is low, and clear to 0 when PciReset and Pwr_ok are both low.
REQ-018 A Next_Bios value >= NUM_BIOS SHALL be latched as 0.
REQ-019 FSM states: IDLE, HOLD, BOOT, RUN, FAIL.
REQ-020 IDLE: Pwr_ok=1 -> HOLD.
REQ-021 PciReset falling edge in BOOT or RUN: Active_Bios <= Next_Bios_latch, retry counter <= 0, -> HOLD.
REQ-022 HOLD: PciReset rising edge -> BOOT, watchdog <= 0.
REQ-023 BOOT: watchdog increments each cycle; Post_Done=1 -> RUN.
REQ-024 BOOT with watchdog == BOOT_TMO-1 and retry < NUM_BIOS-1:
- Active_Bios <= (Active_Bios+1) mod NUM_BIOS; NUM_BIOS-1 wraps to 0.
- retry increments.
- Reset_Req pulses high for exactly one cycle.
- -> HOLD with failover flag set.
REQ-025 HOLD with failover flag set: the next PciReset falling edge SHALL NOT reload Active_Bios from Next_Bios_latch; the flag clears on the next BOOT entry.
REQ-026 BOOT timeout with retry == NUM_BIOS-1: -> FAIL, Boot_Fail=1, no Reset_Req.
REQ-027 Post_Done and timeout in the same cycle: Post_Done wins, -> RUN, no failover.
REQ-028 FAIL SHALL be left only via Pwr_ok=0 or RESET.
REQ-029 Pwr_ok=0 in any state: -> IDLE on the next cycle; Active_Bios, retry, watchdog, failover flag and Boot_Fail clear.
REQ-030 BIOS_CS_N[i] = SPI_PCH_CS0_N when i == Active_Bios and state != FAIL; otherwise 1. Zero latency.

Reset
REQ-031 RESET=1 SHALL force, asynchronously: state IDLE, Active_Bios=0, Next_Bios_latch=0, Reset_Req=0, Boot_Fail=0, watchdog=0, retry=0, synchronisers=0.
REQ-032 RESET asserted mid-BOOT SHALL abort with no Reset_Req pulse.

Configuration
REQ-033 Macro BIOS_FAILOVER_EN: when defined, REQ-023..REQ-028 apply.
REQ-034 Without BIOS_FAILOVER_EN: no watchdog or retry logic; Reset_Req and Boot_Fail are tied to 0; BOOT -> RUN on Post_Done only.

Structure
REQ-035 Shared package bios_pkg SHALL hold the FSM state encoding and the BIOS_NUM_MAX=8 constant.
REQ-036 The 2-flop synchroniser SHALL be the sub-module sync_2ff, instantiated three times.

Verification
REQ-037 NUM_BIOS=2: Pwr_ok=1, Next_Bios=1, PciReset pulse low then high, Post_Done=1 in BOOT -> Active_Bios=1; SPI_PCH_CS0_N=0 gives BIOS_CS_N=2'b01.
REQ-038 NUM_BIOS=4, BOOT_TMO=16, no Post_Done, Active=3 -> one-cycle Reset_Req at cycle 16, Active_Bios=0 (wrap).
REQ-039 NUM_BIOS=3, BOOT_TMO=8, Post_Done never -> three timeouts, then Boot_Fail=1 and BIOS_CS_N=3'b111.
REQ-040 Post_Done asserted on the exact timeout cycle -> state RUN, Reset_Req stays 0.
REQ-041 RESET asserted mid-BOOT -> all outputs reset immediately, no Reset_Req; Pwr_ok=0 in FAIL -> IDLE, Boot_Fail=0.
REQ-042 Build without BIOS_FAILOVER_EN, hold BOOT for 2*BOOT_TMO cycles -> Reset_Req=0, Boot_Fail=0, Active_Bios unchanged.
